// File: rtl/gene_net_pkg.sv
// rtl/gene_net_pkg.sv - shared constants, FSM encoding and popcount helper for the gene network stepper
// Contents: N_GENES, mask slice geometry, state_t (IDLE/RUN/DONE), popcount().
package gene_net_pkg;

   localparam int N_GENES = 8;
   // Each gene owns one SLICE_W-bit slice of a MASK_W-bit mask parameter.
   localparam int SLICE_W = N_GENES;
   localparam int MASK_W  = N_GENES * SLICE_W;
   // Wide enough to hold a count of N_GENES set bits.
   localparam int CNT_W   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [CNT_W-1:0] popcount(input logic [N_GENES-1:0] v);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int k = 0; k < N_GENES; k++) begin
         c = c + CNT_W'(v[k]);
      end
      return c;
   endfunction

endpackage

// File: rtl/gene_update_rule.sv
// rtl/gene_update_rule.sv - combinational threshold update of all genes
// Ports: x[7:0] current state in; next[7:0] next state out.
// Params: ACT_MASK / REP_MASK, slice i lists the activators / repressors of gene i.
module gene_update_rule
   import gene_net_pkg::*;
#(
   parameter logic [MASK_W-1:0] ACT_MASK = '0,
   parameter logic [MASK_W-1:0] REP_MASK = '0
) (
   input  logic [N_GENES-1:0] x,
   output logic [N_GENES-1:0] next
);

   for (genvar g = 0; g < N_GENES; g++) begin : g_gene
      localparam logic [SLICE_W-1:0] ACT_I = ACT_MASK[g*SLICE_W +: SLICE_W];
      localparam logic [SLICE_W-1:0] REP_I = REP_MASK[g*SLICE_W +: SLICE_W];

      logic [CNT_W-1:0] act_cnt;
      logic [CNT_W-1:0] rep_cnt;

      assign act_cnt = popcount(x & ACT_I);
      assign rep_cnt = popcount(x & REP_I);

      // A tie keeps the gene's current value.
      assign next[g] = (act_cnt > rep_cnt) ? 1'b1 :
                       (act_cnt < rep_cnt) ? 1'b0 : x[g];
   end

endmodule

// File: rtl/gene_network_stepper.sv
// rtl/gene_network_stepper.sv - steps an 8-gene threshold network until fixed point or step budget
// Ports: clk, rst (sync, active high), start/init load request, fp_flag halt from checker;
//        x/x_valid current state, init_load checker clear pulse, step_cnt, busy, done, timeout.
module gene_network_stepper
   import gene_net_pkg::*;
#(
   parameter logic [MASK_W-1:0] ACT_MASK  = 64'h0,
   parameter logic [MASK_W-1:0] REP_MASK  = 64'h0,
   parameter int unsigned       MAX_STEPS = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [N_GENES-1:0] init,
   input  logic               fp_flag,
   output logic [N_GENES-1:0] x,
   output logic               x_valid,
   output logic               init_load,
   output logic [7:0]         step_cnt,
   output logic               busy,
   output logic               done,
   output logic               timeout
);

   localparam logic [7:0] STEP_LIMIT = 8'(MAX_STEPS);

   state_t             state, state_n;
   logic [N_GENES-1:0] x_n, x_step;
   logic [7:0]         step_n;
   logic               timeout_n, init_load_n, x_valid_n;

   gene_update_rule #(
      .ACT_MASK (ACT_MASK),
      .REP_MASK (REP_MASK)
   ) u_rule (
      .x    (x),
      .next (x_step)
   );

   always_comb begin
      state_n     = state;
      x_n         = x;
      step_n      = step_cnt;
      timeout_n   = timeout;
      init_load_n = 1'b0;
      x_valid_n   = x_valid;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_n     = RUN;
               x_n         = init;
               step_n      = 8'd0;
               timeout_n   = 1'b0;
               init_load_n = 1'b1;
               x_valid_n   = 1'b1;
            end
         end
         RUN: begin
            // A fixed point wins over an exhausted budget in the same cycle.
            if (fp_flag) begin
               state_n   = DONE;
               timeout_n = 1'b0;
            end else if (step_cnt == STEP_LIMIT) begin
               state_n   = DONE;
               timeout_n = 1'b1;
            end else begin
               x_n    = x_step;
               step_n = step_cnt + 8'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         x         <= '0;
         x_valid   <= 1'b0;
         init_load <= 1'b0;
         step_cnt  <= 8'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state     <= state_n;
         x         <= x_n;
         x_valid   <= x_valid_n;
         init_load <= init_load_n;
         step_cnt  <= step_n;
         busy      <= (state_n == RUN);
         done      <= (state_n == DONE);
         timeout   <= timeout_n;
      end
   end

endmodule

// File: tb/tb_gene_network_stepper.sv
// tb/tb_gene_network_stepper.sv - self-checking bench for gene_network_stepper
module tb_gene_network_stepper;

   localparam logic [63:0] RING  = 64'h4020100804020180;
   localparam logic [63:0] ACT_M = 64'h3c810fa512c36699;
   localparam logic [63:0] REP_M = 64'h4218f05a213c9966;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] init = 8'h00;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   // h: all-zero masks; r4: ring, budget 4; rf: ring with checker; m: mixed masks, budget 20
   logic       start_h = 0, start_r4 = 0, start_rf = 0, start_m = 0;
   logic       fp_h = 0, fp_r4 = 0, fp_m = 0;
   logic       fp_rf;
   logic [7:0] x_h, x_r4, x_rf, x_m, st_h, st_r4, st_rf, st_m;
   logic       xv_h, xv_r4, xv_rf, xv_m, il_h, il_r4, il_rf, il_m;
   logic       bz_h, bz_r4, bz_rf, bz_m, dn_h, dn_r4, dn_rf, dn_m;
   logic       to_h, to_r4, to_rf, to_m;

   gene_network_stepper #(.ACT_MASK(64'h0), .REP_MASK(64'h0), .MAX_STEPS(255)) u_h (
      .clk(clk), .rst(rst), .start(start_h), .init(init), .fp_flag(fp_h), .x(x_h),
      .x_valid(xv_h), .init_load(il_h), .step_cnt(st_h), .busy(bz_h), .done(dn_h), .timeout(to_h));
   gene_network_stepper #(.ACT_MASK(RING), .REP_MASK(64'h0), .MAX_STEPS(4)) u_r4 (
      .clk(clk), .rst(rst), .start(start_r4), .init(init), .fp_flag(fp_r4), .x(x_r4),
      .x_valid(xv_r4), .init_load(il_r4), .step_cnt(st_r4), .busy(bz_r4), .done(dn_r4), .timeout(to_r4));
   gene_network_stepper #(.ACT_MASK(RING), .REP_MASK(64'h0), .MAX_STEPS(255)) u_rf (
      .clk(clk), .rst(rst), .start(start_rf), .init(init), .fp_flag(fp_rf), .x(x_rf),
      .x_valid(xv_rf), .init_load(il_rf), .step_cnt(st_rf), .busy(bz_rf), .done(dn_rf), .timeout(to_rf));
   gene_network_stepper #(.ACT_MASK(ACT_M), .REP_MASK(REP_M), .MAX_STEPS(20)) u_m (
      .clk(clk), .rst(rst), .start(start_m), .init(init), .fp_flag(fp_m), .x(x_m),
      .x_valid(xv_m), .init_load(il_m), .step_cnt(st_m), .busy(bz_m), .done(dn_m), .timeout(to_m));

   // Downstream fixed-point checker: flags when the two latest samples of x agree.
   logic [7:0] chk_prev;
   logic       chk_pv;
   always @(posedge clk) begin
      chk_prev <= x_rf;
      chk_pv   <= xv_rf & ~rst;
   end
   assign fp_rf = xv_rf & chk_pv & ~il_rf & (chk_prev == x_rf);

   function automatic logic [7:0] model_next(input logic [7:0] s, input logic [63:0] act,
                                             input logic [63:0] rep);
      logic [7:0] n;
      for (int i = 0; i < 8; i++) begin
         int a, r;
         a = $countones(s & act[8*i +: 8]);
         r = $countones(s & rep[8*i +: 8]);
         n[i] = (a > r) ? 1'b1 : (a < r) ? 1'b0 : s[i];
      end
      return n;
   endfunction

   function automatic logic [7:0] model_steps(input logic [7:0] s, input logic [63:0] act,
                                              input logic [63:0] rep, input int n);
      logic [7:0] v;
      v = s;
      for (int i = 0; i < n; i++) v = model_next(v, act, rep);
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] exp;
      int         t, halt;
      bit         fin;

      // reset state
      tick(); tick();
      rst = 1'b0;
      chk("rst_h",  {x_h, xv_h, il_h, st_h, bz_h, dn_h, to_h}, 32'd0);
      chk("rst_r4", {x_r4, xv_r4, il_r4, st_r4, bz_r4, dn_r4, to_r4}, 32'd0);
      chk("rst_rf", {x_rf, xv_rf, il_rf, st_rf, bz_rf, dn_rf, to_rf}, 32'd0);
      chk("rst_m",  {x_m, xv_m, il_m, st_m, bz_m, dn_m, to_m}, 32'd0);

      // reset asserted at step 3 aborts the run
      init = 8'h01; start_r4 = 1; tick(); start_r4 = 0;
      chk("load_r4", {x_r4, il_r4, st_r4, bz_r4, xv_r4}, {8'h01, 1'b1, 8'd0, 1'b1, 1'b1});
      tick(); tick(); tick();
      chk("step3_r4", {x_r4, st_r4}, {8'h0f, 8'd3});
      rst = 1; tick(); rst = 0;
      chk("midrst_r4", {x_r4, xv_r4, il_r4, st_r4, bz_r4, dn_r4, to_r4}, 32'd0);
      init = 8'ha5; start_r4 = 1; tick(); start_r4 = 0;
      chk("reload_a5", {x_r4, il_r4, st_r4, bz_r4, dn_r4}, {8'ha5, 1'b1, 8'd0, 1'b1, 1'b0});
      tick();
      chk("a5_step1", {x_r4, il_r4, st_r4}, {model_next(8'ha5, RING, 64'h0), 1'b0, 8'd1});
      for (int c = 0; c < 10 && !dn_r4; c++) tick();
      chk("a5_budget", {x_r4, st_r4, to_r4, dn_r4, bz_r4},
          {model_steps(8'ha5, RING, 64'h0, 4), 8'd4, 1'b1, 1'b1, 1'b0});

      // budget from 0x01
      init = 8'h01; start_r4 = 1; tick(); start_r4 = 0;
      for (int c = 0; c < 10 && !dn_r4; c++) tick();
      chk("budget", {x_r4, st_r4, to_r4, dn_r4, bz_r4, xv_r4}, {8'h1f, 8'd4, 1'b1, 1'b1, 1'b0, 1'b1});
      tick();
      chk("budget_hold", {x_r4, st_r4, dn_r4}, {8'h1f, 8'd4, 1'b1});

      // fp_flag at step_cnt == MAX_STEPS wins over the budget
      init = 8'h01; start_r4 = 1; tick(); start_r4 = 0;
      chk("restart_to_clr", to_r4, 1'b0);
      for (int c = 0; c < 10 && st_r4 != 8'd4; c++) tick();
      fp_r4 = 1; tick(); fp_r4 = 0;
      chk("prio", {x_r4, st_r4, to_r4, dn_r4}, {8'h1f, 8'd4, 1'b0, 1'b1});

      // restart from DONE, then start mid-run is ignored
      init = 8'h80; start_r4 = 1; tick(); start_r4 = 0;
      chk("restart80", {x_r4, il_r4, st_r4, to_r4, bz_r4, dn_r4}, {8'h80, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0});
      tick();
      chk("r80_step1", {x_r4, il_r4, st_r4}, {8'h81, 1'b0, 8'd1});
      init = 8'h33; start_r4 = 1; tick(); start_r4 = 0;
      chk("midrun_start", {x_r4, il_r4, st_r4, bz_r4}, {8'h83, 1'b0, 8'd2, 1'b1});

      // hold network: zero masks
      init = 8'h5a; start_h = 1; tick(); start_h = 0;
      chk("hold_s0", {x_h, st_h}, {8'h5a, 8'd0});
      tick();
      chk("hold_s1", {x_h, st_h}, {8'h5a, 8'd1});
      fp_h = 1; tick(); fp_h = 0;
      chk("hold_done", {x_h, st_h, dn_h, to_h, bz_h, xv_h}, {8'h5a, 8'd1, 1'b1, 1'b0, 1'b0, 1'b1});

      // activation ring with the checker attached
      init = 8'h01; start_rf = 1; tick(); start_rf = 0;
      exp = 8'h01; t = 0;
      chk("ring_s0", {x_rf, st_rf}, {exp, 8'd0});
      for (int c = 0; c < 20 && bz_rf; c++) begin
         tick();
         if (bz_rf) begin
            exp = model_next(exp, RING, 64'h0);
            t++;
            chk("ring_step", {x_rf, st_rf}, {exp, 8'(t)});
         end
      end
      chk("ring_done", {x_rf, st_rf, dn_rf, to_rf}, {8'hff, 8'd8, 1'b1, 1'b0});

      // randomized runs on mixed masks, random halts and ignored mid-run starts
      for (int run = 0; run < 30; run++) begin
         init = 8'($urandom);
         exp = init;
         halt = $urandom_range(1, 26);
         start_m = 1; tick(); start_m = 0;
         chk("m_load", {x_m, il_m, st_m, bz_m, to_m}, {exp, 1'b1, 8'd0, 1'b1, 1'b0});
         t = 0; fin = 0;
         for (int c = 0; c < 40 && !fin; c++) begin
            fp_m = (t == halt);
            start_m = ($urandom_range(0, 3) == 0);
            init = 8'($urandom);
            tick();
            fp_m = 0; start_m = 0;
            if (t == halt) begin
               chk("m_halt", {x_m, st_m, dn_m, bz_m, to_m, xv_m}, {exp, 8'(t), 1'b1, 1'b0, 1'b0, 1'b1});
               fin = 1;
            end else if (t == 20) begin
               chk("m_budget", {x_m, st_m, dn_m, bz_m, to_m}, {exp, 8'd20, 1'b1, 1'b0, 1'b1});
               fin = 1;
            end else begin
               exp = model_next(exp, ACT_M, REP_M);
               t++;
               chk("m_step", {x_m, st_m, bz_m, il_m}, {exp, 8'(t), 1'b1, 1'b0});
            end
         end
         chk("m_finished", 32'(fin), 32'd1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gene_network_stepper.md
# gene_network_stepper

Iterates an 8-gene threshold Boolean network from a loaded initial state and emits one network state per clock. It sits directly upstream of the fixed-point checker: it drives the checker's `x` and a load pulse that clears the checker, and it consumes the checker's `flag` as its halt request. The stepper also enforces a step budget so that non-converging networks terminate.

## Interface
- `ACT_MASK`, default 64'h0, activator masks: gene i uses bits [8i+7:8i]; bit j set means gene j activates gene i.
- `REP_MASK`, default 64'h0, repressor masks, same layout.
- `MAX_STEPS`, default 255, step budget (1..255).
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to load `init`; honoured in IDLE or DONE only.
- `init`  in  8  initial gene state, sampled with `start`.
- `fp_flag`  in  1  fixed-point flag from the downstream checker.
- `x`  out  8  current gene state x[t].
- `x_valid`  out  1  high while `x` is a live network step.
- `init_load`  out  1  one-cycle pulse when a new `init` is loaded; the checker clears on it.
- `step_cnt`  out  8  index t of the state currently on `x`.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `timeout`  out  1  set in DONE when the run ended on the budget rather than on `fp_flag`.

## Operation
- Next-state rule per gene i:
  - a = popcount(x & ACT[i]); r = popcount(x & REP[i]), each 4 bits.
  - next[i] = 1 if a > r; 0 if a < r; x[i] if a == r.
- FSM states: IDLE, RUN, DONE.
  - IDLE, `start`=1: go to RUN. In the same clock load x←init, step_cnt←0, init_load←1, x_valid←1.
  - RUN with `fp_flag`=1: go to DONE with timeout←0. `x` and `step_cnt` freeze.
  - RUN with `fp_flag`=0 and step_cnt == MAX_STEPS: go to DONE with timeout←1, freeze.
  - Otherwise in RUN: x←next(x), step_cnt←step_cnt+1.
  - `fp_flag` has priority over the budget when both hold in the same cycle.
  - DONE, `start`=1: reload exactly as from IDLE and clear timeout. Otherwise hold.
- `start` during RUN is ignored.
- `fp_flag` is ignored outside RUN.
- The checker's flag compares the two most recent samples of `x`. The halt therefore lands one cycle after the repeated state first appears, and `x` freezes on that repeated value.

## Timing
- Reset values: x=0, x_valid=0, init_load=0, step_cnt=0, busy=0, done=0, timeout=0; FSM in IDLE.
- Reset asserted mid-run aborts on the next clock edge. No DONE pulse is produced.
- Load latency: `start` at edge k gives x=init, step 0, init_load=1 after edge k. init_load is 0 after edge k+1.
- Throughput: one new state per clock in RUN.
- `x_valid` stays high through DONE (the frozen state is valid). It falls only on reset.
- `busy` and `done` are mutually exclusive and registered.
- step_cnt never wraps, because MAX_STEPS ≤ 255.

## Structure
- Shared package `gene_net_pkg`:
  - N_GENES=8
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - mask-slice helper constants.
- Sub-module `gene_update_rule`: purely combinational, with parameters ACT_MASK and REP_MASK, input x[7:0] and output next[7:0]. It contains 8 popcount/compare slices.
- The top level holds the FSM, the x/step registers and the outputs.
- The top level also wires to the checker: x→x, fp_flag←flag, init_load→checker clear.

## Test plan
- Reset in RUN: assert `rst` at step 3. Next cycle, all outputs are 0 and the FSM is IDLE. A following `start` with init=0xA5 loads cleanly.
- Hold network: masks 0, init=0x5A, bench drives fp_flag=1 at step 1. Required: x=0x5A throughout, done with timeout=0, step_cnt=1.
- Activation ring: ACT[i]=1<<((i+7)%8), REP=0, init=0x01. Sequence is 0x01,0x03,0x07,…,0xFF at step 7. With the real checker attached, done occurs with step_cnt=8, x=0xFF, timeout=0.
- Budget: same ring, MAX_STEPS=4, fp_flag tied 0. Required: done, timeout=1, x=0x1F, step_cnt=4.
- Priority and restart:
  - fp_flag=1 at step_cnt==MAX_STEPS gives timeout=0.
  - `start` in DONE with init=0x80 gives an init_load pulse, step 0 and timeout cleared.
  - `start` pulsed mid-RUN has no effect.
